// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit with one req/ack transaction per memory op and a pipeline stall while it is outstanding
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_valid_m, i_mem_rd_m, i_mem_wr_m, i_funct3_m, i_addr_m, i_wr_data_m   MEM-stage instruction
//   o_dmem_req/we/addr/be/wdata    registered data-memory request
//   i_dmem_ack, i_dmem_rdata       memory completion and read word
//   o_mem_out_m                    aligned/extended load result for MEM/WB
//   o_stall                        pipeline hold (clk_en = ~o_stall)
//   o_misaligned                   misaligned access flag
//   o_bus_err                      timeout flag, valid in DONE
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid_m,
  input  logic        i_mem_rd_m,
  input  logic        i_mem_wr_m,
  input  logic [2:0]  i_funct3_m,
  input  logic [31:0] i_addr_m,
  input  logic [31:0] i_wr_data_m,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic [31:0] o_mem_out_m,
  output logic        o_stall,
  output logic        o_misaligned,
  output logic        o_bus_err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [7:0] LP_TO = 8'(TIMEOUT_CYCLES);
  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lo;
  logic        r_req, r_we, r_bus_err;
  logic [31:0] r_addr, r_wdata, r_mem_out;
  logic [3:0]  r_be;
  logic        w_op, w_byte, w_half, w_mis, w_timeout, w_r_byte, w_r_half, w_uns;
  logic [7:0]  w_cnt_nxt, w_ld_b;
  logic [15:0] w_ld_h;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load;
  // Codes other than B/H/BU/HU fall through to word accesses.
  assign w_op      = i_valid_m & (i_mem_rd_m | i_mem_wr_m);
  assign w_byte    = i_funct3_m[1:0] == 2'b00;
  assign w_half    = i_funct3_m[1:0] == 2'b01;
  assign w_mis     = w_half ? i_addr_m[0] : (!w_byte && i_addr_m[1:0] != 2'b00);
  assign w_be      = w_byte ? 4'b0001 << i_addr_m[1:0] : w_half ? (i_addr_m[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wdata   = w_byte ? {4{i_wr_data_m[7:0]}} : w_half ? {2{i_wr_data_m[15:0]}} : i_wr_data_m;
  assign w_cnt_nxt = r_cnt + 8'd1;
  assign w_timeout = w_cnt_nxt == LP_TO;
  // Load extraction uses the lane and size captured in IDLE, not the live inputs.
  assign w_r_byte  = r_funct3[1:0] == 2'b00;
  assign w_r_half  = r_funct3[1:0] == 2'b01;
  assign w_uns     = r_funct3[2];
  assign w_ld_b    = r_lo[1] ? (r_lo[0] ? i_dmem_rdata[31:24] : i_dmem_rdata[23:16])
                             : (r_lo[0] ? i_dmem_rdata[15:8]  : i_dmem_rdata[7:0]);
  assign w_ld_h    = r_lo[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
  assign w_load    = w_r_byte ? {{24{~w_uns & w_ld_b[7]}}, w_ld_b}
                   : w_r_half ? {{16{~w_uns & w_ld_h[15]}}, w_ld_h} : i_dmem_rdata;
  assign o_dmem_req   = r_req;
  assign o_dmem_we    = r_we;
  assign o_dmem_addr  = r_addr;
  assign o_dmem_be    = r_be;
  assign o_dmem_wdata = r_wdata;
  assign o_mem_out_m  = r_mem_out;
  assign o_bus_err    = r_bus_err;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // Stall and misaligned are gated by reset so the pipeline never freezes while reset is held.
  always_comb begin
    w_next = r_state;
    o_stall = 1'b0;
    o_misaligned = 1'b0;
    case (r_state)
      IDLE: begin
        o_misaligned = w_op & w_mis;
        o_stall = w_op & ~w_mis;
        w_next = (w_op & ~w_mis) ? BUSY : IDLE;
      end
      BUSY: begin
        o_stall = 1'b1;
        w_next = (i_dmem_ack | w_timeout) ? DONE : BUSY;
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (!i_rst_n) begin
      o_stall = 1'b0;
      o_misaligned = 1'b0;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_funct3 <= '0;
      r_lo <= '0;
      r_req <= 1'b0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_be <= '0;
      r_wdata <= '0;
      r_mem_out <= '0;
      r_bus_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE:
          if (w_op && !w_mis) begin
            r_req <= 1'b1;
            r_we <= i_mem_wr_m;
            r_addr <= {i_addr_m[31:2], 2'b00};
            r_be <= w_be;
            r_wdata <= w_wdata;
            r_funct3 <= i_funct3_m;
            r_lo <= i_addr_m[1:0];
            r_cnt <= '0;
          end else if (w_op) r_mem_out <= '0;
        BUSY: begin
          r_cnt <= w_cnt_nxt;
          if (i_dmem_ack) begin
            r_req <= 1'b0;
            if (!r_we) r_mem_out <= w_load;
          end else if (w_timeout) begin
            r_req <= 1'b0;
            r_mem_out <= '0;
            r_bus_err <= 1'b1;
          end
        end
        DONE: r_bus_err <= 1'b0;
        default: r_bus_err <= 1'b0;
      endcase
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed and random load/store transactions checked against a byte-lane reference model
module tb_mem_stage_lsu;
  localparam int TO = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0, ack = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] addr = '0, wdata = '0, rdata = '0;
  logic        dmem_req, dmem_we, stall, misaligned, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, mem_out;
  logic [3:0]  dmem_be;
  int          vectors = 0, errors = 0;
  logic [31:0] exp_out = '0;
  logic [2:0]  f3_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
  always #5 clk = ~clk;
  mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid_m(valid), .i_mem_rd_m(mem_rd), .i_mem_wr_m(mem_wr),
    .i_funct3_m(f3), .i_addr_m(addr), .i_wr_data_m(wdata),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr), .o_dmem_be(dmem_be),
    .o_dmem_wdata(dmem_wdata), .i_dmem_ack(ack), .i_dmem_rdata(rdata), .o_mem_out_m(mem_out),
    .o_stall(stall), .o_misaligned(misaligned), .o_bus_err(bus_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic int size_of(input logic [2:0] f);
    return (f == 3'd0 || f == 3'd4) ? 1 : (f == 3'd1 || f == 3'd5) ? 2 : 4;
  endfunction
  function automatic logic [3:0] model_be(input logic [2:0] f, input logic [31:0] a);
    int sz = size_of(f);
    return 4'(((1 << sz) - 1) << int'(a % 4));
  endfunction
  function automatic logic [31:0] model_wdata(input logic [2:0] f, input logic [31:0] d);
    int sz = size_of(f);
    if (sz == 1) return {24'b0, d[7:0]} * 32'h0101_0101;
    if (sz == 2) return {16'b0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction
  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] r);
    int sz = size_of(f);
    logic [31:0] w = r >> (8 * int'(a % 4));
    if (sz == 4) return r;
    if (sz == 1) return f[2] ? (w & 32'hFF) : 32'($signed(w[7:0]));
    return f[2] ? (w & 32'hFFFF) : 32'($signed(w[15:0]));
  endfunction
  // Called at a negedge with the unit idle. waits >= TO means memory never acks.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input int waits, input logic [31:0] rdat);
    int sz = size_of(f);
    int stalls = 1;
    bit acked = 0;
    valid = 1'b1; mem_rd = rd; mem_wr = wr; f3 = f; addr = a; wdata = d; ack = 1'b0; rdata = $urandom;
    #1;
    if (int'(a % sz) != 0) begin
      chk("mis_flag", 32'(misaligned), 1);
      chk("mis_stall", 32'(stall), 0);
      @(negedge clk);
      valid = 1'b0;
      exp_out = '0;
      chk("mis_req", 32'(dmem_req), 0);
      chk("mis_out", mem_out, exp_out);
      return;
    end
    chk("idle_stall", 32'(stall), 1);
    chk("idle_mis", 32'(misaligned), 0);
    for (int c = 0; c < TO && !acked; c++) begin
      @(negedge clk);
      chk("busy_req", 32'(dmem_req), 1);
      stalls += int'(stall);
      if (c == 0) begin
        chk("busy_addr", dmem_addr, a & ~32'd3);
        chk("busy_be", 32'(dmem_be), 32'(model_be(f, a)));
        chk("busy_we", 32'(dmem_we), 32'(wr));
        if (wr) chk("busy_wdata", dmem_wdata, model_wdata(f, d));
      end
      if (c == waits) begin ack = 1'b1; rdata = rdat; acked = 1; end
      else begin ack = 1'b0; rdata = $urandom; end
    end
    @(negedge clk);
    valid = 1'b0;
    ack = 1'b1;
    rdata = $urandom;
    if (!acked) exp_out = '0;
    else if (!wr) exp_out = model_load(f, a, rdat);
    chk("done_stall", 32'(stall), 0);
    chk("done_req", 32'(dmem_req), 0);
    chk("done_err", 32'(bus_err), 32'(!acked));
    chk("done_out", mem_out, exp_out);
    chk("stall_cycles", 32'(stalls), 32'(acked ? waits + 2 : TO + 1));
    @(negedge clk);
    ack = 1'b0;
    chk("idle_err", 32'(bus_err), 0);
    chk("idle_out", mem_out, exp_out);
  endtask
  initial begin
    valid = 1'b1; mem_rd = 1'b1; f3 = 3'd2; addr = 32'h100;
    #2;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_out", mem_out, 0);
    chk("rst_err", 32'(bus_err), 0);
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    run_op(1, 0, 3'd2, 32'h104, 0, 0, 32'hDEADBEEF);
    run_op(1, 0, 3'd0, 32'h203, 0, 1, 32'h80FF_0000);
    chk("lb_val", mem_out, 32'hFFFFFF80);
    run_op(1, 0, 3'd4, 32'h203, 0, 0, 32'h80FF_0000);
    chk("lbu_val", mem_out, 32'h00000080);
    run_op(1, 0, 3'd1, 32'h202, 0, 2, 32'h80FF_0000);
    chk("lh_val", mem_out, 32'hFFFF80FF);
    run_op(0, 1, 3'd0, 32'h301, 32'h123456AB, 3, 32'h0);
    chk("sb_hold", mem_out, 32'hFFFF80FF);
    run_op(1, 0, 3'd2, 32'h102, 0, 0, 0);
    run_op(0, 1, 3'd1, 32'h101, 32'h5555, 0, 0);
    run_op(1, 1, 3'd2, 32'h400, 32'hCAFEF00D, 0, 32'h1);
    run_op(1, 0, 3'd5, 32'h402, 0, 0, 32'h9ABC_1234);
    run_op(1, 0, 3'd2, 32'h500, 0, TO, 32'h1234);
    valid = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; ack = 1'b1; rdata = 32'hFFFF_FFFF;
    #1;
    chk("nonmem_stall", 32'(stall), 0);
    chk("nonmem_mis", 32'(misaligned), 0);
    @(negedge clk);
    valid = 1'b0; mem_rd = 1'b1;
    chk("nonmem_req", 32'(dmem_req), 0);
    chk("nonmem_out", mem_out, exp_out);
    @(negedge clk);
    ack = 1'b0; mem_rd = 1'b0;
    chk("bubble_req", 32'(dmem_req), 0);
    chk("bubble_out", mem_out, exp_out);
    run_op(1, 0, 3'd1, 32'h602, 0, 0, 32'h8001_0000);
    valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; f3 = 3'd2; addr = 32'h7F0; wdata = 32'h0;
    @(negedge clk);
    valid = 1'b0;
    chk("pre_rst_req", 32'(dmem_req), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(dmem_req), 0);
    chk("midrst_out", mem_out, 0);
    chk("midrst_be", 32'(dmem_be), 0);
    chk("midrst_addr", dmem_addr, 0);
    chk("midrst_stall", 32'(stall), 0);
    exp_out = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(1, 0, 3'd2, 32'h104, 0, 1, 32'h0BAD_F00D);
    for (int i = 0; i < 40; i++) begin
      logic [2:0] f;
      logic [31:0] a;
      int kind;
      f = f3_tab[$urandom_range(0, 7)];
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(size_of(f) - 1);
      kind = $urandom_range(1, 3);
      run_op(kind[0], kind[1], f, a, $urandom, $urandom_range(0, TO), $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
